// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with a valid/ready input handshake.
// It has a persistent accumulator and an iterative shift-add multiplier.
// Single-cycle ops have a latency of one cycle.
// MUL takes WIDTH cycles in state MUL. Its result and out_valid register on the
// same edge as the last iteration.
module alu_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       fun,
   output logic             out_valid,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_hi,
   output logic             c,
   output logic             z,
   output logic [WIDTH-1:0] acc
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE,
      MUL
   } state_t;

   typedef enum logic [2:0] {
      OP_PASSA = 3'b000,
      OP_SUB   = 3'b001,
      OP_PASSB = 3'b010,
      OP_ADD   = 3'b011,
      OP_NOR   = 3'b100,
      OP_ACCUM = 3'b101,
      OP_MUL   = 3'b110,
      OP_CLR   = 3'b111
   } op_t;

   state_t             state, state_nxt;
   logic               accept;
   logic               mul_last;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_nxt;

   logic [WIDTH:0]     sum_ab;
   logic [WIDTH:0]     diff_ab;
   logic [WIDTH:0]     sum_acc;
   logic [WIDTH-1:0]   op_y;
   logic               op_c;
   logic [WIDTH-1:0]   op_acc;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign mul_last = (state == MUL) && (cnt == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: IDLE -> MUL on an accepted multiply, back after WIDTH iterations
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && (op_t'(fun) == OP_MUL)) state_nxt = MUL;
         MUL:     if (mul_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Single-cycle result selection; the borrow is the top bit of the widened difference
   always_comb begin
      sum_ab  = {1'b0, a} + {1'b0, b};
      diff_ab = {1'b0, a} - {1'b0, b};
      sum_acc = {1'b0, acc} + {1'b0, a};
      op_y    = '0;
      op_c    = 1'b0;
      op_acc  = acc;
      case (op_t'(fun))
         OP_PASSA: op_y = a;
         OP_SUB:   {op_c, op_y} = diff_ab;
         OP_PASSB: op_y = b;
         OP_ADD:   {op_c, op_y} = sum_ab;
         OP_NOR:   op_y = ~(a | b);
         OP_ACCUM: begin
            {op_c, op_y} = sum_acc;
            op_acc       = sum_acc[WIDTH-1:0];
         end
         OP_CLR:   op_acc = '0;
         default:  op_y = '0;
      endcase
   end

   // One shift-add step: add the multiplicand when the current multiplier bit is 1
   always_comb begin
      prod_nxt = prod + (mplier[0] ? mcand : '0);
   end

   // Datapath registers: multiplier iteration, results, flags and accumulator
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
         y         <= '0;
         y_hi      <= '0;
         c         <= 1'b0;
         z         <= 1'b0;
         acc       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (accept) begin
            if (op_t'(fun) == OP_MUL) begin
               cnt    <= '0;
               mcand  <= {{WIDTH{1'b0}}, a};
               mplier <= b;
               prod   <= '0;
            end else begin
               y         <= op_y;
               y_hi      <= '0;
               c         <= op_c;
               z         <= (op_y == '0);
               acc       <= op_acc;
               out_valid <= 1'b1;
            end
         end else if (state == MUL) begin
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            // The last iteration's sum goes straight to the outputs.
            if (mul_last) begin
               y         <= prod_nxt[WIDTH-1:0];
               y_hi      <= prod_nxt[2*WIDTH-1:WIDTH];
               c         <= |prod_nxt[2*WIDTH-1:WIDTH];
               z         <= (prod_nxt == '0);
               out_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq. It drives a WIDTH=4 instance and a WIDTH=8 instance.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       reset;

   logic       in_valid4, in_ready4, out_valid4, c4, z4;
   logic [3:0] a4, b4, y4, y_hi4, acc4;
   logic [2:0] fun4;

   logic       in_valid8, in_ready8, out_valid8, c8, z8;
   logic [7:0] a8, b8, y8, y_hi8, acc8;
   logic [2:0] fun8;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .fun(fun4), .out_valid(out_valid4), .y(y4),
      .y_hi(y_hi4), .c(c4), .z(z4), .acc(acc4)
   );

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .fun(fun8), .out_valid(out_valid8), .y(y8),
      .y_hi(y_hi8), .c(c8), .z(z8), .acc(acc8)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Apply one single-cycle op to dut4 and check the result visible after the accepting edge.
   task automatic op4(input string tag, input logic [2:0] f, input logic [3:0] aa,
                      input logic [3:0] bb, input int ey, input int ec, input int ez,
                      input int eacc);
      in_valid4 = 1'b1;
      fun4 = f;
      a4 = aa;
      b4 = bb;
      check({tag, ".ready"}, 32'(in_ready4), 1);
      step();
      check({tag, ".ov"}, 32'(out_valid4), 1);
      check({tag, ".y"}, 32'(y4), ey);
      check({tag, ".yhi"}, 32'(y_hi4), 0);
      check({tag, ".c"}, 32'(c4), ec);
      check({tag, ".z"}, 32'(z4), ez);
      check({tag, ".acc"}, 32'(acc4), eacc);
   endtask

   task automatic idle4(input string tag);
      in_valid4 = 1'b0;
      step();
      check({tag, ".ov0"}, 32'(out_valid4), 0);
   endtask

   initial begin
      reset = 1'b1;
      in_valid4 = 1'b0; a4 = '0; b4 = '0; fun4 = '0;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; fun8 = '0;
      step();
      step();
      check("rst.ready", 32'(in_ready4), 1);
      check("rst.ov", 32'(out_valid4), 0);
      check("rst.y", 32'(y4), 0);
      check("rst.yhi", 32'(y_hi4), 0);
      check("rst.c", 32'(c4), 0);
      check("rst.z", 32'(z4), 0);
      check("rst.acc", 32'(acc4), 0);
      check("rst8.ready", 32'(in_ready8), 1);
      reset = 1'b0;
      step();

      // Single-cycle ops
      op4("add98", 3'b011, 4'd9, 4'd8, 1, 1, 0, 0);
      op4("sub35", 3'b001, 4'd3, 4'd5, 14, 1, 0, 0);
      op4("sub55", 3'b001, 4'd5, 4'd5, 0, 0, 1, 0);
      op4("nor", 3'b100, 4'd15, 4'd0, 0, 0, 1, 0);
      op4("passa", 3'b000, 4'd11, 4'd2, 11, 0, 0, 0);
      idle4("gap1");
      check("gap1.hold", 32'(y4), 11);

      // MUL 15*15 = 225 = 0xE1, with in_valid held high as an ADD throughout
      in_valid4 = 1'b1; fun4 = 3'b110; a4 = 4'd15; b4 = 4'd15;
      step();
      fun4 = 3'b011; a4 = 4'd1; b4 = 4'd1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("mul.busy%0d", i), 32'(in_ready4), 0);
         check($sformatf("mul.ov%0d", i), 32'(out_valid4), 0);
         if (i < 4) step();
      end
      step();
      check("mul.ov", 32'(out_valid4), 1);
      check("mul.ready", 32'(in_ready4), 1);
      check("mul.y", 32'(y4), 1);
      check("mul.yhi", 32'(y_hi4), 14);
      check("mul.c", 32'(c4), 1);
      check("mul.z", 32'(z4), 0);
      idle4("mul.after");
      check("mul.hold_yhi", 32'(y_hi4), 14);

      op4("passb", 3'b010, 4'd3, 4'd6, 6, 0, 0, 0);

      // Accumulator
      op4("clr", 3'b111, 4'd9, 4'd9, 0, 0, 1, 0);
      op4("acc1", 3'b101, 4'd7, 4'd0, 7, 0, 0, 7);
      op4("acc2", 3'b101, 4'd7, 4'd0, 14, 0, 0, 14);
      op4("acc3", 3'b101, 4'd7, 4'd0, 5, 1, 0, 5);
      op4("add12", 3'b011, 4'd1, 4'd2, 3, 0, 0, 5);
      idle4("gap2");

      // Reset two cycles into MUL 3*4
      in_valid4 = 1'b1; fun4 = 3'b110; a4 = 4'd3; b4 = 4'd4;
      step();
      in_valid4 = 1'b0;
      step();
      check("abort.busy", 32'(in_ready4), 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort.ready", 32'(in_ready4), 1);
      check("abort.acc", 32'(acc4), 0);
      check("abort.y", 32'(y4), 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("abort.ov%0d", i), 32'(out_valid4), 0);
         step();
      end

      // Fresh MUL 3*4 = 12
      in_valid4 = 1'b1; fun4 = 3'b110; a4 = 4'd3; b4 = 4'd4;
      step();
      in_valid4 = 1'b0;
      for (int i = 1; i < 4; i++) step();
      check("mul12.ov_early", 32'(out_valid4), 0);
      step();
      check("mul12.ov", 32'(out_valid4), 1);
      check("mul12.y", 32'(y4), 12);
      check("mul12.yhi", 32'(y_hi4), 0);
      check("mul12.c", 32'(c4), 0);
      check("mul12.z", 32'(z4), 0);

      // WIDTH=8: MUL 255*2 = 510 = 0x1FE
      in_valid8 = 1'b1; fun8 = 3'b110; a8 = 8'd255; b8 = 8'd2;
      step();
      in_valid8 = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("mul8.ov%0d", i), 32'(out_valid8), 0);
         step();
      end
      check("mul8.ov", 32'(out_valid8), 1);
      check("mul8.y", 32'(y8), 254);
      check("mul8.yhi", 32'(y_hi8), 1);
      check("mul8.c", 32'(c8), 1);

      // WIDTH=8: ADD 200+100 = 300 -> 44 with carry
      in_valid8 = 1'b1; fun8 = 3'b011; a8 = 8'd200; b8 = 8'd100;
      step();
      in_valid8 = 1'b0;
      check("add8.ov", 32'(out_valid8), 1);
      check("add8.y", 32'(y8), 44);
      check("add8.c", 32'(c8), 1);
      check("add8.yhi", 32'(y_hi8), 0);
      check("add8.acc", 32'(acc8), 0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the lab combinational ALU.
- Registered WIDTH-bit ALU with a valid/ready input handshake and registered result and flags.
- Adds a persistent accumulator and a multi-cycle shift-add multiplier.
- Sits between an operand source (switch/register file or test FSM) and a display/result consumer that samples on out_valid.

Parameters:
WIDTH, 4, operand/result width in bits (legal range 2..16).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands/opcode present
in_ready  output  1  block can accept; combinational, =1 iff state==IDLE
a  input  WIDTH  operand A (unsigned)
b  input  WIDTH  operand B (unsigned)
fun  input  3  opcode
out_valid  output  1  one-cycle pulse: y/y_hi/c/z/acc updated this cycle
y  output  WIDTH  result, low word
y_hi  output  WIDTH  high word of product; 0 for non-MUL ops
c  output  1  carry / borrow / product-overflow flag
z  output  1  y==0 (MUL: full 2*WIDTH product==0)
acc  output  WIDTH  accumulator value

Behaviour:
- One clock; reset is synchronous and active-high. On the reset edge, all registers clear:
  - y, y_hi, c, z, acc, out_valid = 0.
  - State = IDLE, so in_ready = 1 in the cycle after reset.
  - in_valid is ignored while reset is high.
- Accept: a, b, fun are captured on the rising edge where in_valid && in_ready.
- Opcodes, with all arithmetic modulo 2^WIDTH:
  - 000 PASSA: y=a, c=0.
  - 001 SUB: y=a-b; c=1 iff a<b (borrow).
  - 010 PASSB: y=b, c=0.
  - 011 ADD: y=a+b; c=carry out of bit WIDTH-1.
  - 100 NOR: y=~(a|b), c=0.
  - 101 ACCUM: acc=acc+a; y=new acc; c=carry out.
  - 110 MUL: {y_hi,y}=a*b; c=1 iff y_hi!=0. Multi-cycle, see below.
  - 111 CLR: acc=0, y=0, c=0, z=1.
- y_hi is written to 0 by every non-MUL op.
- acc changes only on ACCUM, CLR and reset.
- Single-cycle ops (all except 110):
  - Results and out_valid are registered on the accepting edge; out_valid is high in the following cycle (latency 1).
  - State remains IDLE, so back-to-back accepts give one result per cycle.
- MUL, iterative shift-add:
  - Accepting edge enters state MUL, with counter=0 and a 2*WIDTH partial product=0.
  - Each MUL cycle adds the shifted multiplicand when the current multiplier bit is 1, then increments the counter.
  - After WIDTH iterations: state returns to IDLE and outputs plus out_valid are registered.
  - out_valid is high WIDTH+1 cycles after the accepting edge.
  - in_ready=0 from the accepting edge until the out_valid cycle; in_ready=1 in the out_valid cycle, so a new op may be accepted then.
- Between operations, y/y_hi/c/z/acc hold their last values and out_valid=0.
- in_valid while in_ready=0 is ignored. There is no queuing; the source must hold in_valid.
- Reset during MUL aborts the operation: no out_valid, state=IDLE, all outputs 0.
- Opcode values are fully decoded; no op is illegal.

Test Plan:
- WIDTH=4, reset 2 cycles -> outputs 0, in_ready=1. Accept ADD a=9 b=8 -> next cycle out_valid=1, y=1, c=1, z=0.
- SUB a=3 b=5 -> y=14, c=1. SUB a=5 b=5 -> y=0, c=0, z=1. NOR a=15 b=0 -> y=0, z=1. PASSB b=6 -> y=6, y_hi=0.
- MUL a=15 b=15 accepted at cycle T -> in_ready=0 over T+1..T+4; out_valid only at T+5 with y=1, y_hi=14, c=1, z=0. in_valid held high during MUL is not accepted.
- Accumulator: CLR, then ACCUM a=7, 7, 7 back-to-back -> acc and y equal 7, 14, 5 on three consecutive out_valid pulses; the third has c=1. ADD afterwards leaves acc=5.
- Reset asserted 2 cycles into MUL a=3 b=4 -> no out_valid, acc=0, in_ready=1 next cycle. A fresh MUL 3*4 -> y=12, y_hi=0, c=0.
- WIDTH=8 regression: MUL a=255 b=2 -> y=254, y_hi=1, c=1, out_valid 9 cycles after accept. ADD 200+100 -> y=44, c=1.
